// File: rtl/mips_decode_alu.sv
// MIPS-subset ID/EX helper: PC+4, main/ALU control decode, 32-bit ALU and a clocked syscall print/halt unit.
// Build option: define ALU_EXT_EN to enable ALU ops 011 XOR, 100 NOR, 101 SLTU (otherwise they yield 0).
module mips_decode_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic [31:0] syscall_info,
  input  logic [31:0] std_out,
  output logic        reg_dst,
  output logic        jump,
  output logic        branch,
  output logic        mem_read,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src,
  output logic        mem_write,
  output logic [2:0]  alu_control,
  output logic        illegal,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [2:0]  alu_ctl,
  output logic [31:0] alu_out,
  output logic        alu_zero,
  output logic        print_valid,
  output logic [31:0] print_data,
  output logic        halt
);

  logic [5:0] w_opcode;
  logic [5:0] w_funct;
  logic       w_is_syscall;
  logic       r_print_valid;
  logic [31:0] r_print_data;
  logic       r_halt;

  assign pc_plus4     = pc + 32'd4;
  assign w_opcode     = instr[31:26];
  assign w_funct      = instr[5:0];
  assign w_is_syscall = (w_opcode == 6'h00) && (w_funct == 6'h0C);

  always_comb begin
    reg_dst     = 1'b0;
    jump        = 1'b0;
    branch      = 1'b0;
    mem_read    = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src     = 1'b0;
    mem_write   = 1'b0;
    alu_control = 3'b010;
    illegal     = 1'b0;
    case (w_opcode)
      6'h00: begin
        // R-type: controls only asserted for recognised functs
        case (w_funct)
          6'h20, 6'h21: begin reg_dst = 1'b1; reg_write = 1'b1; alu_control = 3'b010; end
          6'h22, 6'h23: begin reg_dst = 1'b1; reg_write = 1'b1; alu_control = 3'b110; end
          6'h24:        begin reg_dst = 1'b1; reg_write = 1'b1; alu_control = 3'b000; end
          6'h25:        begin reg_dst = 1'b1; reg_write = 1'b1; alu_control = 3'b001; end
          6'h2A:        begin reg_dst = 1'b1; reg_write = 1'b1; alu_control = 3'b111; end
          6'h0C:        alu_control = 3'b010;
          default: begin
            alu_control = 3'b000;
            illegal     = 1'b1;
          end
        endcase
      end
      6'h23: begin alu_src = 1'b1; mem_to_reg = 1'b1; mem_read = 1'b1; reg_write = 1'b1; end
      6'h2B: begin alu_src = 1'b1; mem_write = 1'b1; end
      6'h04: begin branch = 1'b1; alu_control = 3'b110; end
      6'h08, 6'h09: begin alu_src = 1'b1; reg_write = 1'b1; end
      6'h0A: begin alu_src = 1'b1; reg_write = 1'b1; alu_control = 3'b111; end
      6'h0C: begin alu_src = 1'b1; reg_write = 1'b1; alu_control = 3'b000; end
      6'h0D: begin alu_src = 1'b1; reg_write = 1'b1; alu_control = 3'b001; end
      6'h02: jump = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    alu_out = 32'd0;
    case (alu_ctl)
      3'b000: alu_out = alu_a & alu_b;
      3'b001: alu_out = alu_a | alu_b;
      3'b010: alu_out = alu_a + alu_b;
      3'b110: alu_out = alu_a - alu_b;
      3'b111: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
`ifdef ALU_EXT_EN
      3'b011: alu_out = alu_a ^ alu_b;
      3'b100: alu_out = ~(alu_a | alu_b);
      3'b101: alu_out = {31'd0, alu_a < alu_b};
`else
      default: alu_out = 32'd0;
`endif
    endcase
  end

  assign alu_zero = (alu_out == 32'd0);

  // Print strobe and data live for exactly one cycle per syscall-1 edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_print_valid <= 1'b0;
      r_print_data  <= 32'd0;
      r_halt        <= 1'b0;
    end else begin
      r_print_valid <= w_is_syscall && (syscall_info == 32'd1);
      r_print_data  <= (w_is_syscall && (syscall_info == 32'd1)) ? std_out : 32'd0;
      if (w_is_syscall && (syscall_info == 32'd10))
        r_halt <= 1'b1;
    end
  end

  assign print_valid = r_print_valid;
  assign print_data  = r_print_data;
  assign halt        = r_halt;

endmodule

// File: tb/tb_mips_decode_alu.sv
// Directed-vector bench for mips_decode_alu: PC+4, decode table, ALU ops and syscall print/halt/reset.
module tb_mips_decode_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, pc_plus4, instr, syscall_info, std_out;
  logic        reg_dst, jump, branch, mem_read, mem_to_reg, reg_write, alu_src, mem_write;
  logic [2:0]  alu_control;
  logic        illegal;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_ctl;
  logic        alu_zero, print_valid, halt;
  logic [31:0] print_data;

  int checks = 0;
  int failures = 0;

  mips_decode_alu dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_plus4(pc_plus4), .instr(instr),
    .syscall_info(syscall_info), .std_out(std_out),
    .reg_dst(reg_dst), .jump(jump), .branch(branch), .mem_read(mem_read),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src(alu_src), .mem_write(mem_write),
    .alu_control(alu_control), .illegal(illegal),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .alu_out(alu_out), .alu_zero(alu_zero),
    .print_valid(print_valid), .print_data(print_data), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // {reg_dst,jump,branch,mem_read,mem_to_reg,reg_write,alu_src,mem_write,alu_control,illegal}
  function automatic logic [11:0] ctrl_vec();
    return {reg_dst, jump, branch, mem_read, mem_to_reg, reg_write, alu_src, mem_write,
            alu_control, illegal};
  endfunction

  typedef struct {
    logic [31:0] ins;
    logic [11:0] exp;
    logic [11:0] mask;
    string       tag;
  } dec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctl;
    logic [31:0] exp;
    string       tag;
  } alu_t;

  dec_t dec_tab[$];
  alu_t alu_tab[$];

  initial begin
    rst = 1'b1; pc = 32'h0; instr = 32'h0; syscall_info = 32'h0; std_out = 32'h0;
    alu_a = 32'h0; alu_b = 32'h0; alu_ctl = 3'b000;

    dec_tab = '{
      '{32'h8C880004, {8'b0001_1110, 3'b010, 1'b0}, 12'hFFF, "dec_lw"},
      '{32'h012A402A, {8'b1000_0100, 3'b111, 1'b0}, 12'hFFF, "dec_slt"},
      '{32'hFC000000, {8'b0000_0000, 3'b010, 1'b1}, 12'hFFF, "dec_badop"},
      '{32'h01095020, {8'b1000_0100, 3'b010, 1'b0}, 12'hFFF, "dec_add"},
      '{32'h01095021, {8'b1000_0100, 3'b010, 1'b0}, 12'hFFF, "dec_addu"},
      '{32'h01095022, {8'b1000_0100, 3'b110, 1'b0}, 12'hFFF, "dec_sub"},
      '{32'h01095023, {8'b1000_0100, 3'b110, 1'b0}, 12'hFFF, "dec_subu"},
      '{32'h01095024, {8'b1000_0100, 3'b000, 1'b0}, 12'hFFF, "dec_and"},
      '{32'h01095025, {8'b1000_0100, 3'b001, 1'b0}, 12'hFFF, "dec_or"},
      '{32'h0000000C, {8'b0000_0000, 3'b010, 1'b0}, 12'hFFF, "dec_syscall"},
      '{32'h00000000, {8'b0000_0000, 3'b000, 1'b1}, 12'hFF1, "dec_badfunct"},
      '{32'hAC880004, {8'b0000_0011, 3'b010, 1'b0}, 12'hFFF, "dec_sw"},
      '{32'h1109FFFF, {8'b0010_0000, 3'b110, 1'b0}, 12'hFFF, "dec_beq"},
      '{32'h21080001, {8'b0000_0110, 3'b010, 1'b0}, 12'hFFF, "dec_addi"},
      '{32'h25080001, {8'b0000_0110, 3'b010, 1'b0}, 12'hFFF, "dec_addiu"},
      '{32'h29080001, {8'b0000_0110, 3'b111, 1'b0}, 12'hFFF, "dec_slti"},
      '{32'h31080001, {8'b0000_0110, 3'b000, 1'b0}, 12'hFFF, "dec_andi"},
      '{32'h35080001, {8'b0000_0110, 3'b001, 1'b0}, 12'hFFF, "dec_ori"},
      '{32'h08000010, {8'b0100_0000, 3'b010, 1'b0}, 12'hFFF, "dec_j"}
    };

    alu_tab = '{
      '{32'hFFFFFFFF, 32'h00000001, 3'b111, 32'h00000001, "alu_slt_neg"},
      '{32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, "alu_add_wrap"},
      '{32'hFFFFFFFF, 32'h00000001, 3'b110, 32'hFFFFFFFE, "alu_sub"},
      '{32'h00000000, 32'h00000001, 3'b110, 32'hFFFFFFFF, "alu_sub_wrap"},
      '{32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 32'hF000F000, "alu_and"},
      '{32'hF0F0F0F0, 32'hFF00FF00, 3'b001, 32'hFFF0FFF0, "alu_or"},
      '{32'h00000005, 32'hFFFFFFFD, 3'b111, 32'h00000000, "alu_slt_pos"},
      '{32'h12345678, 32'h11111111, 3'b010, 32'h23456789, "alu_add"},
`ifdef ALU_EXT_EN
      '{32'hF0F0F0F0, 32'hFF00FF00, 3'b011, 32'h0FF00FF0, "alu_xor"},
      '{32'hF0F0F0F0, 32'hFF00FF00, 3'b100, 32'h000F000F, "alu_nor"},
      '{32'hFFFFFFFF, 32'h00000001, 3'b101, 32'h00000000, "alu_sltu_a"},
      '{32'h00000001, 32'hFFFFFFFF, 3'b101, 32'h00000001, "alu_sltu_b"}
`else
      '{32'hF0F0F0F0, 32'hFF00FF00, 3'b011, 32'h00000000, "alu_op3_off"},
      '{32'hF0F0F0F0, 32'hFF00FF00, 3'b100, 32'h00000000, "alu_op4_off"},
      '{32'h00000001, 32'hFFFFFFFF, 3'b101, 32'h00000000, "alu_op5_off"}
`endif
    };

    #2;
    chk("rst_print_valid", {31'd0, print_valid}, 32'd0);
    chk("rst_print_data", print_data, 32'd0);
    chk("rst_halt", {31'd0, halt}, 32'd0);

    @(negedge clk); rst = 1'b0;

    pc = 32'hFFFFFFFC; #1 chk("pc4_wrap", pc_plus4, 32'h00000000);
    pc = 32'h00400000; #1 chk("pc4", pc_plus4, 32'h00400004);

    foreach (dec_tab[i]) begin
      instr = dec_tab[i].ins;
      #1 chk(dec_tab[i].tag, {20'd0, ctrl_vec() & dec_tab[i].mask},
             {20'd0, dec_tab[i].exp & dec_tab[i].mask});
    end

    foreach (alu_tab[i]) begin
      alu_a = alu_tab[i].a; alu_b = alu_tab[i].b; alu_ctl = alu_tab[i].ctl;
      #1 chk(alu_tab[i].tag, alu_out, alu_tab[i].exp);
      chk({alu_tab[i].tag, "_zero"}, {31'd0, alu_zero}, {31'd0, alu_tab[i].exp == 32'd0});
    end

    // single print
    @(negedge clk); instr = 32'h01095020; syscall_info = 32'd1; std_out = 32'd42;
    @(posedge clk); #1 chk("no_print_non_syscall", {31'd0, print_valid}, 32'd0);
    @(negedge clk); instr = 32'h0000000C;
    @(posedge clk); #1;
    chk("print_valid", {31'd0, print_valid}, 32'd1);
    chk("print_data", print_data, 32'd42);
    instr = 32'h01095020;
    @(posedge clk); #1 chk("print_one_cycle", {31'd0, print_valid}, 32'd0);

    // held syscall: one strobe per cycle, data follows std_out
    @(negedge clk); instr = 32'h0000000C;
    for (int k = 0; k < 3; k++) begin
      std_out = 32'h100 + k;
      @(posedge clk); #1;
      chk("held_valid", {31'd0, print_valid}, 32'd1);
      chk("held_data", print_data, 32'h100 + k);
    end
    instr = 32'h01095020;
    @(posedge clk); #1 chk("held_end", {31'd0, print_valid}, 32'd0);

    // unknown syscall code ignored
    @(negedge clk); instr = 32'h0000000C; syscall_info = 32'd5;
    @(posedge clk); #1;
    chk("code5_valid", {31'd0, print_valid}, 32'd0);
    chk("code5_halt", {31'd0, halt}, 32'd0);

    // exit: sticky halt, decode unaffected
    @(negedge clk); syscall_info = 32'd10;
    @(posedge clk); #1;
    chk("halt_set", {31'd0, halt}, 32'd1);
    chk("halt_no_print", {31'd0, print_valid}, 32'd0);
    instr = 32'h8C880004; syscall_info = 32'd0;
    repeat (3) @(posedge clk);
    #1 chk("halt_sticky", {31'd0, halt}, 32'd1);
    chk("decode_while_halt", {20'd0, ctrl_vec()}, {20'd0, 8'b0001_1110, 3'b010, 1'b0});

    // async reset mid-cycle with a print pending in the register
    @(negedge clk); instr = 32'h0000000C; syscall_info = 32'd1; std_out = 32'd7;
    @(posedge clk); #1 chk("pre_rst_valid", {31'd0, print_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_halt", {31'd0, halt}, 32'd0);
    chk("arst_valid", {31'd0, print_valid}, 32'd0);
    chk("arst_data", print_data, 32'd0);
    chk("arst_decode", {20'd0, ctrl_vec()}, {20'd0, 8'b0000_0000, 3'b010, 1'b0});
    @(negedge clk); rst = 1'b0; instr = 32'h01095020;
    @(posedge clk); #1 chk("post_rst_halt", {31'd0, halt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
